// File: rtl/sipo_pkg.sv
// Shared types for the framed serial receiver: FSM states, error pulse bundle,
// and the bit-counter width helper.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic overrun;
    } rx_err_t;

    // Counter must index 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Serial-in strobe plus one-entry parallel valid/ready output of the receiver.
// master = bit-timing front end / consumer side, slave = receiver.
interface sipo_rx_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             sdi;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;

    modport master (
        output sdi, sin_valid, dout_ready,
        input  dout, dout_valid, busy, parity_err, frame_err, overrun
    );

    modport slave (
        input  sdi, sin_valid, dout_ready,
        output dout, dout_valid, busy, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in/parallel-out shifter, new bits enter at the LSB.
// One-cycle update; clear has priority over shift; no backpressure.
module sipo_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (clr) begin
            shreg_d = '0;
        end else if (shift_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdi};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q = shreg_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framed serial receiver: start bit, WIDTH data bits MSB-first, optional even parity, stop bit.
// Word visible the cycle after the stop strobe; a full, unaccepted buffer drops the new word.
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input logic           clk,
    input logic           reset_n,
    sipo_rx_ctrl_if.slave rx
);

    localparam int                 CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    rx_err_t           err_q, err_d;

    logic [WIDTH-1:0]  shreg;
    logic              start_det;
    logic              shift_en;
    logic              load;
    logic              accept;

    assign accept = dout_valid_q & rx.dout_ready;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (start_det),
        .shift_en (shift_en),
        .sdi      (rx.sdi),
        .q        (shreg)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        perr_d    = perr_q;
        start_det = 1'b0;
        shift_en  = 1'b0;
        load      = 1'b0;
        err_d     = '0;
        if (rx.sin_valid) begin
            case (state_q)
                IDLE: begin
                    if (!rx.sdi) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                        perr_d    = 1'b0;
                        start_det = 1'b1;
                    end
                end
                DATA: begin
                    shift_en  = 1'b1;
                    par_d     = par_q ^ rx.sdi;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    // Data ones plus parity bit must be even.
                    perr_d  = par_q ^ rx.sdi;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!rx.sdi) begin
                        err_d.frame_err  = 1'b1;
                        err_d.parity_err = perr_q;
                    end else if (perr_q) begin
                        err_d.parity_err = 1'b1;
                    end else if (!dout_valid_q || rx.dout_ready) begin
                        load = 1'b1;
                    end else begin
                        err_d.overrun = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A load in the same cycle as an accept wins, keeping valid high.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (load) begin
            dout_d       = shreg;
            dout_valid_d = 1'b1;
        end else if (accept) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = dout_valid_q;
    assign rx.busy       = (state_q != IDLE);
    assign rx.parity_err = err_q.parity_err;
    assign rx.frame_err  = err_q.frame_err;
    assign rx.overrun    = err_q.overrun;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Bench for sipo_rx_ctrl: two instances (4-bit with parity, 5-bit without) share one
// serial stream; a frame-level reference model predicts every output every cycle.
`timescale 1ns/1ps
module tb_sipo_rx_ctrl;

    localparam int W0 = 4;
    localparam int W1 = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    sipo_rx_ctrl_if #(.WIDTH(W0)) if0 ();
    sipo_rx_ctrl_if #(.WIDTH(W1)) if1 ();

    sipo_rx_ctrl #(.WIDTH(W0), .PARITY_EN(1'b1)) u_dut0 (.clk(clk), .reset_n(reset_n), .rx(if0));
    sipo_rx_ctrl #(.WIDTH(W1), .PARITY_EN(1'b0)) u_dut1 (.clk(clk), .reset_n(reset_n), .rx(if1));

    logic [31:0] o_dout [2];
    logic        o_vld  [2];
    logic        o_busy [2];
    logic        o_perr [2];
    logic        o_ferr [2];
    logic        o_ovr  [2];

    assign o_dout[0] = 32'(if0.dout);
    assign o_dout[1] = 32'(if1.dout);
    assign o_vld[0]  = if0.dout_valid;
    assign o_vld[1]  = if1.dout_valid;
    assign o_busy[0] = if0.busy;
    assign o_busy[1] = if1.busy;
    assign o_perr[0] = if0.parity_err;
    assign o_perr[1] = if1.parity_err;
    assign o_ferr[0] = if0.frame_err;
    assign o_ferr[1] = if1.frame_err;
    assign o_ovr[0]  = if0.overrun;
    assign o_ovr[1]  = if1.overrun;

    // Reference model: per instance, position within the current frame and the
    // collected frame bits; the whole frame is judged once its stop bit arrives.
    int          wid [2] = '{W0, W1};
    bit          pen [2] = '{1'b1, 1'b0};
    int          pos [2];
    bit          fr  [2][64];
    bit          e_vld  [2];
    bit          e_perr [2];
    bit          e_ferr [2];
    bit          e_ovr  [2];
    logic [31:0] e_dout [2];

    int n_chk    = 0;
    int n_fail   = 0;
    int rdy_mode = 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d dout_valid", d), 32'(o_vld[d]),  32'(e_vld[d]));
            check_eq($sformatf("d%0d dout", d),       o_dout[d],      e_dout[d]);
            check_eq($sformatf("d%0d busy", d),       32'(o_busy[d]), 32'(pos[d] != 0));
            check_eq($sformatf("d%0d parity_err", d), 32'(o_perr[d]), 32'(e_perr[d]));
            check_eq($sformatf("d%0d frame_err", d),  32'(o_ferr[d]), 32'(e_ferr[d]));
            check_eq($sformatf("d%0d overrun", d),    32'(o_ovr[d]),  32'(e_ovr[d]));
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            pos[d]    = 0;
            e_vld[d]  = 1'b0;
            e_perr[d] = 1'b0;
            e_ferr[d] = 1'b0;
            e_ovr[d]  = 1'b0;
            e_dout[d] = '0;
        end
    endfunction

    function automatic void model_step(input int d, input bit sv, input bit sd, input bit rdy);
        bit          old_vld;
        bit          acc;
        bit          pbad;
        bit          stop;
        int          flen;
        logic [31:0] data;
        old_vld   = e_vld[d];
        acc       = e_vld[d] & rdy;
        flen      = 2 + wid[d] + int'(pen[d]);
        e_perr[d] = 1'b0;
        e_ferr[d] = 1'b0;
        e_ovr[d]  = 1'b0;
        if (acc) e_vld[d] = 1'b0;
        if (!sv) return;
        if (pos[d] == 0) begin
            if (!sd) pos[d] = 1;
            return;
        end
        fr[d][pos[d]] = sd;
        pos[d]++;
        if (pos[d] < flen) return;
        pos[d] = 0;
        data   = '0;
        for (int i = 1; i <= wid[d]; i++) data = (data << 1) | 32'(fr[d][i]);
        pbad = pen[d] && ((^data) != fr[d][wid[d] + 1]);
        stop = fr[d][flen - 1];
        if (!stop) begin
            e_ferr[d] = 1'b1;
            e_perr[d] = pbad;
        end else if (pbad) begin
            e_perr[d] = 1'b1;
        end else if (!old_vld || acc) begin
            e_vld[d]  = 1'b1;
            e_dout[d] = data;
        end else begin
            e_ovr[d] = 1'b1;
        end
    endfunction

    // One clock: drive inputs just after posedge, check at negedge, advance model.
    task automatic cyc(input bit sv, input bit sd);
        bit rdy;
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = bit'($urandom_range(0, 1));
        endcase
        if (!sv) sd = bit'($urandom_range(0, 1));
        if0.sin_valid  = sv;
        if1.sin_valid  = sv;
        if0.sdi        = sd;
        if1.sdi        = sd;
        if0.dout_ready = rdy;
        if1.dout_ready = rdy;
        @(negedge clk);
        check_outputs();
        for (int d = 0; d < 2; d++) model_step(d, sv, sd, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int gap);
        repeat (gap) cyc(1'b0, 1'b0);
        cyc(1'b1, b);
    endtask

    task automatic send_frame(input int w, input bit p_en, input logic [31:0] data,
                              input bit pflip, input bit stop, input int maxgap, input int startgap);
        send_bit(1'b0, startgap);
        for (int i = w - 1; i >= 0; i--) send_bit(data[i], $urandom_range(0, maxgap));
        if (p_en) send_bit((^data) ^ pflip, $urandom_range(0, maxgap));
        send_bit(stop, $urandom_range(0, maxgap));
    endtask

    task automatic apply_reset();
        if0.sin_valid  = 1'b0;
        if1.sin_valid  = 1'b0;
        if0.dout_ready = 1'b0;
        if1.dout_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          dsel;
        if0.sin_valid = 1'b0; if0.sdi = 1'b1; if0.dout_ready = 1'b0;
        if1.sin_valid = 1'b0; if1.sdi = 1'b1; if1.dout_ready = 1'b0;
        #1;
        apply_reset();

        // Good frame 1011, parity 1.
        rdy_mode = 1;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        send_frame(W0, 1'b1, 32'hB, 1'b0, 1'b1, 0, 0);
        check_eq("t1 dout", 32'(if0.dout), 32'hB);
        check_eq("t1 valid", 32'(if0.dout_valid), 32'd1);
        check_eq("t1 perr", 32'(if0.parity_err), 32'd0);
        check_eq("t1 ferr", 32'(if0.frame_err), 32'd0);

        // Same frame, wrong parity bit.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        send_frame(W0, 1'b1, 32'hB, 1'b1, 1'b1, 0, 0);
        check_eq("t2 perr", 32'(if0.parity_err), 32'd1);
        check_eq("t2 valid", 32'(if0.dout_valid), 32'd0);
        cyc(1'b0, 1'b0);
        check_eq("t2 perr width", 32'(if0.parity_err), 32'd0);

        // Stop bit 0, then a good 0110.
        send_frame(W0, 1'b1, 32'hC, 1'b0, 1'b0, 0, 0);
        check_eq("t3 ferr", 32'(if0.frame_err), 32'd1);
        check_eq("t3 valid", 32'(if0.dout_valid), 32'd0);
        check_eq("t3 busy", 32'(if0.busy), 32'd0);
        send_frame(W0, 1'b1, 32'h6, 1'b0, 1'b1, 1, 0);
        check_eq("t3 dout", 32'(if0.dout), 32'h6);
        check_eq("t3 valid2", 32'(if0.dout_valid), 32'd1);

        // Overrun with consumer stalled.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rdy_mode = 0;
        send_frame(W0, 1'b1, 32'hB, 1'b0, 1'b1, 0, 0);
        check_eq("t4 dout first", 32'(if0.dout), 32'hB);
        send_frame(W0, 1'b1, 32'h5, 1'b0, 1'b1, 0, 0);
        check_eq("t4 overrun", 32'(if0.overrun), 32'd1);
        check_eq("t4 dout held", 32'(if0.dout), 32'hB);
        check_eq("t4 valid held", 32'(if0.dout_valid), 32'd1);
        rdy_mode = 1;
        cyc(1'b0, 1'b0);
        check_eq("t4 drained", 32'(if0.dout_valid), 32'd0);

        // Reset mid-frame, then 1100.
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        apply_reset();
        send_frame(W0, 1'b1, 32'hC, 1'b0, 1'b1, 0, 0);
        check_eq("t5 dout", 32'(if0.dout), 32'hC);
        check_eq("t5 valid", 32'(if0.dout_valid), 32'd1);

        // No-parity instance: back-to-back frames with strobe gaps.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            a = $urandom() & 32'h1F;
            b = $urandom() & 32'h1F;
            send_frame(W1, 1'b0, a, 1'b0, 1'b1, 3, 0);
            check_eq("t6 first word", 32'(if1.dout), a);
            check_eq("t6 busy gap", 32'(if1.busy), 32'd0);
            send_frame(W1, 1'b0, b, 1'b0, 1'b1, 3, 0);
            check_eq("t6 second word", 32'(if1.dout), b);
            check_eq("t6 second valid", 32'(if1.dout_valid), 32'd1);
            apply_reset();
        end

        // Randomised traffic in either frame format.
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            dsel = $urandom_range(0, 1);
            a    = $urandom() & ((32'd1 << wid[dsel]) - 1);
            if ($urandom_range(0, 19) == 0) begin
                send_bit(1'b0, $urandom_range(0, 2));
                repeat ($urandom_range(0, 4)) send_bit(bit'($urandom_range(0, 1)), $urandom_range(0, 2));
                apply_reset();
            end else begin
                send_frame(wid[dsel], pen[dsel], a, ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) send_bit(1'b1, $urandom_range(0, 2));
            end
        end
        repeat (4) cyc(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
